cdb_arbiter: RTL and testbench

- Shares the CDB_W common-data-bus broadcast slots among NUM_FU functional-unit result producers.
- The buses feed reservation-station wakeup (tag/value compare) and ROB completion.
- Each FU has a one-entry holding register with a valid/ready handshake.
- A rotating round-robin pointer grants up to CDB_W held results per cycle onto registered CDB outputs.

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU one-entry holds, rotating round-robin grant onto CDB_W registered buses.
// Optional CDB_BYPASS_EN lets a handshaking FU skip its hold into a bus slot left free by hold grants.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned CDB_W  = 2,
  parameter int unsigned PHYS_W = 6,
  parameter int unsigned ROB_W  = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              fu_valid,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [NUM_FU-1:0][PHYS_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][63:0]        fu_value,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_tag,
  output logic [CDB_W-1:0]               cdb_valid,
  output logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
  output logic [CDB_W-1:0][63:0]         cdb_value,
  output logic [CDB_W-1:0][ROB_W-1:0]    cdb_rob_tag
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]              hold_valid;
  logic [NUM_FU-1:0][PHYS_W-1:0]  hold_tag;
  logic [NUM_FU-1:0][63:0]        hold_value;
  logic [NUM_FU-1:0][ROB_W-1:0]   hold_rob_tag;
  logic [PTR_W-1:0]               rr_ptr;

  logic [NUM_FU-1:0]              grant;
  logic [NUM_FU-1:0]              bypass;
  logic [CDB_W-1:0]               slot_used;
  logic [CDB_W-1:0][PHYS_W-1:0]   slot_tag;
  logic [CDB_W-1:0][63:0]         slot_value;
  logic [CDB_W-1:0][ROB_W-1:0]    slot_rob_tag;
  logic                           any_serviced;
  logic [PTR_W-1:0]               next_ptr;
  logic [PTR_W-1:0]               idx;
  int                             pos;
  int                             n_used;
  int                             last_k;

  // Round-robin scan from rr_ptr; k-th serviced FU in scan order drives slot k.
  always_comb begin
    grant        = '0;
    bypass       = '0;
    slot_used    = '0;
    slot_tag     = '0;
    slot_value   = '0;
    slot_rob_tag = '0;
    any_serviced = 1'b0;
    next_ptr     = rr_ptr;
    idx          = '0;
    pos          = 0;
    n_used       = 0;
    last_k       = -1;

    for (int k = 0; k < int'(NUM_FU); k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= int'(NUM_FU)) pos = pos - int'(NUM_FU);
      idx = PTR_W'(pos);
      if (hold_valid[idx] && (n_used < int'(CDB_W))) begin
        grant[idx] = 1'b1;
        for (int b = 0; b < int'(CDB_W); b++) begin
          if (b == n_used) begin
            slot_used[b]    = 1'b1;
            slot_tag[b]     = hold_tag[idx];
            slot_value[b]   = hold_value[idx];
            slot_rob_tag[b] = hold_rob_tag[idx];
          end
        end
        n_used = n_used + 1;
        last_k = k;
      end
    end

    // A granted entry frees its hold for a same-cycle refill.
    fu_ready = {NUM_FU{~flush}} & (~hold_valid | grant);

`ifdef CDB_BYPASS_EN
    for (int k = 0; k < int'(NUM_FU); k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= int'(NUM_FU)) pos = pos - int'(NUM_FU);
      idx = PTR_W'(pos);
      if (fu_valid[idx] && fu_ready[idx] && (n_used < int'(CDB_W))) begin
        bypass[idx] = 1'b1;
        for (int b = 0; b < int'(CDB_W); b++) begin
          if (b == n_used) begin
            slot_used[b]    = 1'b1;
            slot_tag[b]     = fu_tag[idx];
            slot_value[b]   = fu_value[idx];
            slot_rob_tag[b] = fu_rob_tag[idx];
          end
        end
        n_used = n_used + 1;
        if (k > last_k) last_k = k;
      end
    end
`endif

    // Pointer moves past the furthest serviced FU in scan order.
    if (last_k >= 0) begin
      any_serviced = 1'b1;
      pos = int'(rr_ptr) + last_k + 1;
      if (pos >= int'(NUM_FU)) pos = pos - int'(NUM_FU);
      next_ptr = PTR_W'(pos);
    end
  end

  // Holds, bus registers and pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid   <= '0;
      hold_tag     <= '0;
      hold_value   <= '0;
      hold_rob_tag <= '0;
      cdb_valid    <= '0;
      cdb_tag      <= '0;
      cdb_value    <= '0;
      cdb_rob_tag  <= '0;
      rr_ptr       <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid  <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (fu_valid[i] && fu_ready[i] && !bypass[i]) begin
          hold_valid[i]   <= 1'b1;
          hold_tag[i]     <= fu_tag[i];
          hold_value[i]   <= fu_value[i];
          hold_rob_tag[i] <= fu_rob_tag[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      cdb_valid <= slot_used;
      for (int b = 0; b < int'(CDB_W); b++) begin
        if (slot_used[b]) begin
          cdb_tag[b]     <= slot_tag[b];
          cdb_value[b]   <= slot_value[b];
          cdb_rob_tag[b] <= slot_rob_tag[b];
        end
      end
      if (any_serviced) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_FU=4, CDB_W=2), default build.
module tb_cdb_arbiter;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic [3:0]           fu_valid;
  logic [3:0]           fu_ready;
  logic [3:0][5:0]      fu_tag;
  logic [3:0][63:0]     fu_value;
  logic [3:0][5:0]      fu_rob_tag;
  logic [1:0]           cdb_valid;
  logic [1:0][5:0]      cdb_tag;
  logic [1:0][63:0]     cdb_value;
  logic [1:0][5:0]      cdb_rob_tag;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(4), .CDB_W(2), .PHYS_W(6), .ROB_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_tag(fu_tag), .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_rob_tag(cdb_rob_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic put(input int fu, input logic [5:0] tag, input logic [63:0] val, input logic [5:0] rob);
    fu_valid[fu]   = 1'b1;
    fu_tag[fu]     = tag;
    fu_value[fu]   = val;
    fu_rob_tag[fu] = rob;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; fu_valid = '0;
    fu_tag = '0; fu_value = '0; fu_rob_tag = '0;
    #12;
    sample();
    check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    check("rst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    step(); reset = 1'b0;
    sample();
    check("rst_ready", 64'(fu_ready), 64'hF);

    // Single FU: two-cycle latency
    step(); put(1, 6'h05, 64'hDEAD, 6'd3);
    sample();
    check("s_ready_n", 64'(fu_ready[1]), 64'h1);
    step(); fu_valid = '0;
    sample();
    check("s_cdb_n1", 64'(cdb_valid), 64'h0);
    check("s_ready_n1", 64'(fu_ready[1]), 64'h1);
    step();
    sample();
    check("s_valid", 64'(cdb_valid), 64'h1);
    check("s_tag", 64'(cdb_tag[0]), 64'h05);
    check("s_value", cdb_value[0], 64'hDEAD);
    check("s_rob", 64'(cdb_rob_tag[0]), 64'd3);
    check("s_ptr", 64'(dut.rr_ptr), 64'd2);
    step();
    sample();
    check("s_once", 64'(cdb_valid), 64'h0);

    // Flush to bring rr_ptr to 0, then contention
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    sample();
    check("c_ptr0", 64'(dut.rr_ptr), 64'd0);
    step();
    for (int i = 0; i < 4; i++) put(i, 6'(10 + i), 64'(100 + i), 6'(20 + i));
    step(); fu_valid = '0;
    sample();
    check("c_ready_n1", 64'(fu_ready), 64'h3);
    check("c_cdb_n1", 64'(cdb_valid), 64'h0);
    step();
    sample();
    check("c_valid_n2", 64'(cdb_valid), 64'h3);
    check("c_tag0_n2", 64'(cdb_tag[0]), 64'd10);
    check("c_tag1_n2", 64'(cdb_tag[1]), 64'd11);
    check("c_val1_n2", cdb_value[1], 64'd101);
    step();
    sample();
    check("c_valid_n3", 64'(cdb_valid), 64'h3);
    check("c_tag0_n3", 64'(cdb_tag[0]), 64'd12);
    check("c_tag1_n3", 64'(cdb_tag[1]), 64'd13);
    check("c_rob1_n3", 64'(cdb_rob_tag[1]), 64'd23);
    check("c_ptr_n3", 64'(dut.rr_ptr), 64'd0);
    step();
    sample();
    check("c_idle", 64'(cdb_valid), 64'h0);

    // Round-robin wrap: FU2 moves ptr to 3, then FU3 and FU0 held
    step(); put(2, 6'h22, 64'h2222, 6'd2);
    step(); fu_valid = '0; put(3, 6'h33, 64'h3333, 6'd4); put(0, 6'h30, 64'h3030, 6'd5);
    step(); fu_valid = '0;
    sample();
    check("w_tag_fu2", 64'(cdb_tag[0]), 64'h22);
    check("w_ptr3", 64'(dut.rr_ptr), 64'd3);
    step();
    sample();
    check("w_valid", 64'(cdb_valid), 64'h3);
    check("w_bus0", 64'(cdb_tag[0]), 64'h33);
    check("w_bus1", 64'(cdb_tag[1]), 64'h30);
    check("w_ptr1", 64'(dut.rr_ptr), 64'd1);

    // Sustained stream from FU0
    for (int j = 0; j < 11; j++) begin
      step();
      if (j < 8) put(0, 6'(8 + j), 64'(1000 + j), 6'(j));
      else fu_valid = '0;
      sample();
      if (j < 8) check("t_ready", 64'(fu_ready[0]), 64'h1);
      if (j >= 2 && j < 10) begin
        check("t_valid", 64'(cdb_valid), 64'h1);
        check("t_tag", 64'(cdb_tag[0]), 64'(8 + j - 2));
        check("t_value", cdb_value[0], 64'(1000 + j - 2));
      end
      if (j == 10) check("t_idle", 64'(cdb_valid), 64'h0);
    end

    // Flush with two entries held
    step(); put(1, 6'h41, 64'h41, 6'd1); put(2, 6'h42, 64'h42, 6'd2);
    step(); fu_valid = '0; flush = 1'b1;
    sample();
    check("f_ready", 64'(fu_ready), 64'h0);
    step(); flush = 1'b0;
    sample();
    check("f_cdb1", 64'(cdb_valid), 64'h0);
    check("f_ptr", 64'(dut.rr_ptr), 64'd0);
    check("f_ready_after", 64'(fu_ready), 64'hF);
    step();
    sample();
    check("f_cdb2", 64'(cdb_valid), 64'h0);

    // Async reset mid-broadcast
    step(); put(1, 6'h37, 64'h7777, 6'd7);
    step(); fu_valid = '0;
    step();
    sample();
    check("r_pre_valid", 64'(cdb_valid), 64'h1);
    check("r_pre_ptr", 64'(dut.rr_ptr), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("r_async_valid", 64'(cdb_valid), 64'h0);
    check("r_async_ptr", 64'(dut.rr_ptr), 64'd0);
    step(); reset = 1'b0;
    sample();
    check("r_ready", 64'(fu_ready), 64'hF);
    step();
    sample();
    check("r_idle", 64'(cdb_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
